avalon_burst_bridge: RTL and testbench

Parametrised Avalon-MM burst master that turns one command (address, beat count, byte enables, direction) into a single Avalon burst transaction. Write data enters and read data leaves on simple valid/ready beat streams. It sits between the stack core's memory port and the SDRAM controller, replacing single-beat access with bursts of up to MAX_BURST beats. Waitrequest stalls are honoured per beat, and read beats are counted to burst completion.

---
 rtl/avalon_burst_bridge.sv | 147 ++++++++++++++
 tb/tb_avalon_burst_bridge.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_burst_bridge.sv
// Avalon-MM burst master: one command becomes one Avalon burst; write beats in, read beats out.
// Latency: request asserts the cycle after command accept; read beats appear 1 cycle after readdatavalid.
// Backpressure: waitrequest stalls write beats (wr_ready) and the read request; rd stream has none.
module avalon_burst_bridge #(
    parameter int ADDR_SIZE = 32,
    parameter int DATA_SIZE = 256,
    parameter int MAX_BURST = 16,
    parameter int LEN_W     = $clog2(MAX_BURST) + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   avm_m0_read,
    output logic                   avm_m0_write,
    output logic [ADDR_SIZE-1:0]   avm_m0_address,
    output logic [10:0]            avm_m0_burstcount,
    output logic [DATA_SIZE/8-1:0] avm_m0_byteenable,
    output logic [DATA_SIZE-1:0]   avm_m0_writedata,
    input  logic [DATA_SIZE-1:0]   avm_m0_readdata,
    input  logic                   avm_m0_readdatavalid,
    input  logic                   avm_m0_waitrequest,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_write,
    input  logic [ADDR_SIZE-1:0]   cmd_address,
    input  logic [LEN_W-1:0]       cmd_len,
    input  logic [DATA_SIZE/8-1:0] cmd_byteenable,
    input  logic [DATA_SIZE-1:0]   wr_data,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    output logic [DATA_SIZE-1:0]   rd_data,
    output logic                   rd_valid,
    output logic                   rd_last,
    output logic                   done,
    output logic                   busy
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WRITE     = 2'd1;
    localparam logic [1:0] READ_CMD  = 2'd2;
    localparam logic [1:0] READ_DATA = 2'd3;

    localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BURST);

    logic [1:0]             state;
    logic [LEN_W-1:0]       len_q;
    logic [LEN_W-1:0]       cnt;
    logic [ADDR_SIZE-1:0]   addr_q;
    logic [DATA_SIZE/8-1:0] be_q;
    logic [LEN_W-1:0]       eff_len;
    logic [10:0]            burst_len;
    logic                   last_beat;
    logic                   wr_beat;
    logic                   in_write;

    assign in_write  = (state == WRITE);
    assign last_beat = (cnt == len_q - ONE);
    assign wr_beat   = in_write && wr_valid && !avm_m0_waitrequest;

    // Clamp requested length into 1..MAX_BURST; zero means a single beat.
    always_comb begin
        eff_len = cmd_len;
        if (cmd_len == '0)
            eff_len = ONE;
        else if (cmd_len > MAX_LEN)
            eff_len = MAX_LEN;
    end

    // Widen the held length onto the 11-bit Avalon burstcount.
    always_comb begin
        burst_len = '0;
        burst_len[LEN_W-1:0] = len_q;
    end

    // Burst sequencer: capture the command, count beats, return to IDLE on the final one.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            len_q  <= '0;
            cnt    <= '0;
            addr_q <= '0;
            be_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        addr_q <= cmd_address;
                        be_q   <= cmd_byteenable;
                        len_q  <= eff_len;
                        cnt    <= '0;
                        state  <= cmd_write ? WRITE : READ_CMD;
                    end
                end
                WRITE: begin
                    if (wr_beat) begin
                        cnt <= cnt + ONE;
                        if (last_beat)
                            state <= IDLE;
                    end
                end
                READ_CMD: begin
                    if (!avm_m0_waitrequest)
                        state <= READ_DATA;
                end
                READ_DATA: begin
                    if (avm_m0_readdatavalid) begin
                        cnt <= cnt + ONE;
                        if (last_beat)
                            state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read return stage: register each accepted beat and flag the final one; stray beats are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            if (state == READ_DATA && avm_m0_readdatavalid) begin
                rd_data  <= avm_m0_readdata;
                rd_valid <= 1'b1;
                rd_last  <= last_beat;
            end
        end
    end

    // Avalon side is held constant from registers for the whole burst and reads 0 when idle.
    assign busy              = (state != IDLE);
    assign cmd_ready         = (state == IDLE);
    assign avm_m0_address    = busy ? addr_q : '0;
    assign avm_m0_burstcount = busy ? burst_len : '0;
    assign avm_m0_byteenable = busy ? be_q : '0;
    assign avm_m0_read       = (state == READ_CMD);
    assign avm_m0_write      = in_write && wr_valid;
    assign avm_m0_writedata  = in_write ? wr_data : '0;
    assign wr_ready          = in_write && !avm_m0_waitrequest;
    // Write completion is combinational with the last beat; read completion rides with rd_last.
    assign done              = (wr_beat && last_beat) || rd_last;

endmodule

// File: tb/tb_avalon_burst_bridge.sv
// Testbench for avalon_burst_bridge: scripted commands with a write/read beat scoreboard.
// Latency: write beats expected same cycle as handshake; read beats 1 cycle after readdatavalid.
// Backpressure: waitrequest stalls and wr_valid gaps are injected by the stimulus.
module tb_avalon_burst_bridge;

    localparam int AW = 32;
    localparam int DW = 256;
    localparam int MB = 16;
    localparam int LW = $clog2(MB) + 1;
    localparam int BW = DW / 8;

    typedef logic [DW-1:0] w_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          avm_m0_read, avm_m0_write;
    logic [AW-1:0] avm_m0_address;
    logic [10:0]   avm_m0_burstcount;
    logic [BW-1:0] avm_m0_byteenable;
    logic [DW-1:0] avm_m0_writedata;
    logic [DW-1:0] avm_m0_readdata = '0;
    logic          avm_m0_readdatavalid = 1'b0;
    logic          avm_m0_waitrequest = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_address = '0;
    logic [LW-1:0] cmd_len = '0;
    logic [BW-1:0] cmd_byteenable = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [DW-1:0] rd_data;
    logic          rd_valid, rd_last, done, busy;

    avalon_burst_bridge #(.ADDR_SIZE(AW), .DATA_SIZE(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .reset(reset),
        .avm_m0_read(avm_m0_read), .avm_m0_write(avm_m0_write),
        .avm_m0_address(avm_m0_address), .avm_m0_burstcount(avm_m0_burstcount),
        .avm_m0_byteenable(avm_m0_byteenable), .avm_m0_writedata(avm_m0_writedata),
        .avm_m0_readdata(avm_m0_readdata), .avm_m0_readdatavalid(avm_m0_readdatavalid),
        .avm_m0_waitrequest(avm_m0_waitrequest),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_address(cmd_address), .cmd_len(cmd_len), .cmd_byteenable(cmd_byteenable),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last),
        .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Scoreboard and expected command context
    w_t            wr_q[$];
    w_t            rd_q[$];
    bit            rdl_q[$];
    logic [AW-1:0] e_addr = '0;
    int            e_len = 0;
    logic [BW-1:0] e_be = '0;
    bit            rdv_live = 1'b0;
    bit            rdv_prev = 1'b0;
    int            wr_seen = 0;

    task automatic chk(input string tag, input w_t act, input w_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic int eff(input int l);
        if (l == 0) return 1;
        if (l > MB) return MB;
        return l;
    endfunction

    function automatic w_t rnd();
        w_t r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops expected beats when the DUT produces them, checks held burst fields and done.
    always @(negedge clk) begin
        bit exp_done;
        w_t d;
        bit l;
        if (!reset) begin
            exp_done = 1'b0;
            chk("rw_excl", w_t'(avm_m0_read & avm_m0_write), w_t'(0));
            if (avm_m0_read || avm_m0_write) begin
                chk("addr", w_t'(avm_m0_address), w_t'(e_addr));
                chk("bcnt", w_t'(avm_m0_burstcount), w_t'(e_len));
                chk("be", w_t'(avm_m0_byteenable), w_t'(e_be));
            end
            if (avm_m0_write && !avm_m0_waitrequest) begin
                chk("wr_rdy", w_t'(wr_ready), w_t'(1));
                if (wr_q.size() == 0)
                    chk("wr_extra", w_t'(avm_m0_write), w_t'(0));
                else
                    chk("wr_data", avm_m0_writedata, wr_q.pop_front());
                if (wr_seen == e_len - 1) exp_done = 1'b1;
                wr_seen++;
            end
            chk("rd_vld_t", w_t'(rd_valid), w_t'(rdv_prev));
            if (rd_valid) begin
                if (rd_q.size() == 0) begin
                    chk("rd_extra", w_t'(rd_valid), w_t'(0));
                end else begin
                    d = rd_q.pop_front();
                    l = rdl_q.pop_front();
                    chk("rd_data", rd_data, d);
                    chk("rd_last", w_t'(rd_last), w_t'(l));
                    if (l) exp_done = 1'b1;
                end
            end
            chk("done", w_t'(done), w_t'(exp_done));
            if (cmd_valid && cmd_ready) wr_seen = 0;
        end
        rdv_prev = rdv_live;
    end

    task automatic send_cmd(input bit wr, input logic [AW-1:0] a, input int l,
                            input logic [BW-1:0] be, output int waited);
        bit acc = 1'b0;
        waited = 0;
        cmd_valid = 1'b1; cmd_write = wr; cmd_address = a;
        cmd_len = LW'(l); cmd_byteenable = be;
        while (!acc && waited < 50) begin
            #3;
            acc = cmd_ready;
            if (acc) begin e_addr = a; e_len = eff(l); e_be = be; end
            step();
            if (!acc) waited++;
        end
        cmd_valid = 1'b0;
        chk("cmd_accept", w_t'(acc), w_t'(1));
    endtask

    // Drive n write beats; optional waitrequest stall on one beat and one wr_valid gap on another.
    task automatic run_write(input int n, input int stall_beat, input int stall_cyc,
                             input int gap_beat, output int cycles);
        int b = 0; int st = 0; bit gap_done = 1'b0; bit pushed = 1'b0; bit took;
        w_t d;
        cycles = 0;
        while (b < n && cycles < 200) begin
            avm_m0_waitrequest = 1'b0;
            if (b == gap_beat && !gap_done) begin
                wr_valid = 1'b0;
                gap_done = 1'b1;
            end else begin
                if (!pushed) begin d = rnd(); wr_data = d; wr_q.push_back(d); pushed = 1'b1; end
                wr_valid = 1'b1;
                if (b == stall_beat && st < stall_cyc) begin avm_m0_waitrequest = 1'b1; st++; end
            end
            #3;
            took = wr_valid && wr_ready;
            step();
            cycles++;
            if (took) begin b++; pushed = 1'b0; end
        end
        wr_valid = 1'b0;
        avm_m0_waitrequest = 1'b0;
        chk("wr_beats", w_t'(b), w_t'(n));
    endtask

    // Stall the read request wcyc cycles, then return ndrive beats of an n-beat burst.
    task automatic run_read(input int n, input int wcyc, input bit gaps, input int ndrive);
        int k = 0; int held = 0; bit go = 1'b0; w_t d;
        while (!go && k < 50) begin
            avm_m0_waitrequest = (k < wcyc);
            #3;
            if (avm_m0_read) held++;
            go = avm_m0_read && !avm_m0_waitrequest;
            step();
            k++;
        end
        avm_m0_waitrequest = 1'b0;
        chk("rd_held", w_t'(held), w_t'(wcyc + 1));
        for (int i = 0; i < ndrive; i++) begin
            if (gaps && (i % 3 == 2)) step();
            d = rnd();
            avm_m0_readdata = d;
            avm_m0_readdatavalid = 1'b1;
            rdv_live = 1'b1;
            rd_q.push_back(d);
            rdl_q.push_back(i == n - 1);
            step();
            avm_m0_readdatavalid = 1'b0;
            rdv_live = 1'b0;
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_cmd_ready"}, w_t'(cmd_ready), w_t'(1));
        chk({tag, "_busy"}, w_t'(busy), w_t'(0));
        chk({tag, "_avm"}, w_t'({avm_m0_read, avm_m0_write, avm_m0_address,
                                 avm_m0_burstcount, avm_m0_byteenable}), w_t'(0));
        chk({tag, "_rd"}, w_t'({rd_valid, rd_last, done, wr_ready}), w_t'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int w, cyc;
        repeat (3) step();
        reset = 1'b0;
        #3;
        check_idle("reset");
        step();

        // Zero-stall 4-beat write: 4 cycles, cmd_ready right after
        send_cmd(1'b1, 32'h100, 4, '1, w);
        run_write(4, -1, 0, -1, cyc);
        chk("wr4_cycles", w_t'(cyc), w_t'(4));
        #3; chk("wr4_cmd_ready", w_t'(cmd_ready), w_t'(1));
        step();

        // 3-beat write with 2-cycle stall on beat 1 and a valid gap on beat 2
        send_cmd(1'b1, 32'h200, 3, BW'($urandom), w);
        run_write(3, 1, 2, 2, cyc);
        chk("wr3_cycles", w_t'(cyc), w_t'(6));
        chk("wr3_sb_empty", w_t'(wr_q.size()), w_t'(0));
        step();

        // 8-beat read, 3 waitrequest cycles, gapped readdatavalid
        send_cmd(1'b0, 32'h40, 8, '1, w);
        run_read(8, 3, 1'b1, 8);
        #3; chk("rd8_cmd_ready", w_t'(cmd_ready), w_t'(1));
        #3; chk("rd8_sb_empty", w_t'(rd_q.size()), w_t'(0));
        step();

        // Length clamps: 0 -> 1 beat write, MB+5 -> MB beat read
        send_cmd(1'b1, 32'h300, 0, BW'($urandom), w);
        run_write(1, -1, 0, -1, cyc);
        chk("len0_cycles", w_t'(cyc), w_t'(1));
        step();
        send_cmd(1'b0, 32'h400, MB + 5, '1, w);
        run_read(MB, 0, 1'b0, MB);
        #3; #3; chk("lenmax_sb_empty", w_t'(rd_q.size()), w_t'(0));
        step();

        // Reset after 2 of 8 read beats, then stray readdatavalid
        send_cmd(1'b0, 32'h500, 8, '1, w);
        run_read(8, 0, 1'b0, 2);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        #3;
        check_idle("abort");
        for (int i = 0; i < 6; i++) begin
            avm_m0_readdata = rnd();
            avm_m0_readdatavalid = 1'b1;
            step();
        end
        avm_m0_readdatavalid = 1'b0;
        chk("abort_sb_empty", w_t'(rd_q.size()), w_t'(0));
        send_cmd(1'b1, 32'h600, 2, '1, w);
        run_write(2, -1, 0, -1, cyc);
        chk("post_abort_cycles", w_t'(cyc), w_t'(2));
        step();

        // Back-to-back: read then write accepted the cycle rd_last is high
        send_cmd(1'b0, 32'h700, 4, BW'($urandom), w);
        run_read(4, 1, 1'b0, 4);
        send_cmd(1'b1, 32'h800, 2, '1, w);
        chk("b2b_wait", w_t'(w), w_t'(0));
        run_write(2, -1, 0, -1, cyc);
        chk("b2b_wr_cycles", w_t'(cyc), w_t'(2));
        step();
        #3;
        chk("end_sb_empty", w_t'(wr_q.size() + rd_q.size()), w_t'(0));
        check_idle("end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
